// File: rtl/r_format_exec_unit.sv
// rtl/r_format_exec_unit.sv - multi-cycle MIPS R-format execute stage (IDLE/READ/EXEC/WB).
// Optional signed-overflow trap on add/sub: define OVERFLOW_TRAP_EN (adds the ovf port).
module r_format_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] rs_address,
  output logic [ADDR_WIDTH-1:0] rt_address,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic [ADDR_WIDTH-1:0] rd_address,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  write_enable,
  output logic                  done,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  retired_count
`ifdef OVERFLOW_TRAP_EN
  ,
  output logic                  ovf
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [31:0]           instr_q, instr_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [ADDR_WIDTH-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_WIDTH-1:0] wb_q, wb_d;
  logic                  we_q, we_d, done_q, done_d, ill_q, ill_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [5:0]            opcode, funct;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] sum, diff, alu_res;
  logic                  alu_legal, trap;

  assign opcode = instr_q[31:26];
  assign funct  = instr_q[5:0];
  assign shamt  = instr_q[10:6];
  assign sum    = op_a_q + op_b_q;
  assign diff   = op_a_q - op_b_q;

  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (funct)
      6'h20, 6'h21: alu_res = sum;
      6'h22, 6'h23: alu_res = diff;
      6'h24:        alu_res = op_a_q & op_b_q;
      6'h25:        alu_res = op_a_q | op_b_q;
      6'h26:        alu_res = op_a_q ^ op_b_q;
      6'h27:        alu_res = ~(op_a_q | op_b_q);
      6'h2A:        alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a_q) < $signed(op_b_q)};
      6'h2B:        alu_res = {{(DATA_WIDTH-1){1'b0}}, op_a_q < op_b_q};
      6'h00:        alu_res = op_b_q << shamt;
      6'h02:        alu_res = op_b_q >> shamt;
      6'h03:        alu_res = $unsigned($signed(op_b_q) >>> shamt);
      default:      alu_legal = 1'b0;
    endcase
    if (opcode != 6'h00) alu_legal = 1'b0;
  end

`ifdef OVERFLOW_TRAP_EN
  // Signed overflow: like-signed operands (add) or unlike-signed (sub) flipping the sign of a.
  assign trap = alu_legal &&
                ((funct == 6'h20 && op_a_q[31] == op_b_q[31] && sum[31]  != op_a_q[31]) ||
                 (funct == 6'h22 && op_a_q[31] != op_b_q[31] && diff[31] != op_a_q[31]));
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    wb_d    = wb_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    ill_d   = 1'b0;
`ifdef OVERFLOW_TRAP_EN
    ovf_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          rs_d    = instr[25:21];
          rt_d    = instr[20:16];
          state_d = READ;
        end
      end
      READ: begin
        op_a_d  = rs_data;
        op_b_d  = rt_data;
        state_d = EXEC;
      end
      EXEC: begin
        // Write-back outputs are registered here so they appear during WB.
        rd_d    = instr_q[15:11];
        wb_d    = alu_legal ? alu_res : '0;
        we_d    = alu_legal && !trap && (instr_q[15:11] != 5'd0);
        ill_d   = !alu_legal;
        done_d  = 1'b1;
        cnt_d   = cnt_q + 1'b1;
`ifdef OVERFLOW_TRAP_EN
        ovf_d   = trap;
`endif
        state_d = WB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      wb_q    <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef OVERFLOW_TRAP_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
      we_q    <= we_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
`ifdef OVERFLOW_TRAP_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign instr_ready   = (state_q == IDLE);
  assign rs_address    = rs_q;
  assign rt_address    = rt_q;
  assign rd_address    = rd_q;
  assign wb_data       = wb_q;
  assign write_enable  = we_q;
  assign done          = done_q;
  assign illegal       = ill_q;
  assign retired_count = cnt_q;

endmodule
